// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the multicore lane register bank.
// Op encodings for the common op bus and default bank geometry.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_ADD  = 3'd4,
    OP_CLR  = 3'd5
  } op_t;

  localparam int DEF_WIDTH     = 12;
  localparam int DEF_NUM_CORES = 4;

endpackage

// File: rtl/inc_register_lane.sv
// One lane of the register bank: next-state, overflow pulse and zero flag.
// Wrap or clamp behaviour on INC/DEC/ADD is chosen by SATURATE.
module inc_register_lane
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] add_val,
  output logic [WIDTH-1:0] value,
  output logic             zero,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam bit               SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] value_q, value_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   inc_w, add_w;
  op_t              op_e;

  assign op_e  = op_t'(op);
  assign inc_w = {1'b0, value_q} + {{WIDTH{1'b0}}, 1'b1};
  assign add_w = {1'b0, value_q} + {1'b0, add_val};

  always_comb begin
    value_d = value_q;
    ovf_d   = 1'b0;
    if (en) begin
      unique case (1'b1)
        op_e == OP_LOAD: value_d = load_val;
        op_e == OP_CLR:  value_d = '0;
        op_e == OP_INC: begin
          ovf_d   = inc_w[WIDTH];
          value_d = (inc_w[WIDTH] && SAT) ? MAX_VAL
                                          : inc_w[WIDTH-1:0];
        end
        op_e == OP_DEC: begin
          ovf_d   = (value_q == '0);
          value_d = (value_q == '0 && SAT) ? '0
                                           : value_q - 1'b1;
        end
        op_e == OP_ADD: begin
          ovf_d   = add_w[WIDTH];
          value_d = (add_w[WIDTH] && SAT) ? MAX_VAL
                                          : add_w[WIDTH-1:0];
        end
        // HOLD and the unused encodings keep the value
        default: value_d = value_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      value_q <= RESET_VAL;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value = value_q;
  assign ovf   = ovf_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/multi_inc_register.sv
// Per-core register bank: NUM_CORES lanes sharing one op bus.
// Top level only slices lane data and muxes the broadcast load source.
module multi_inc_register
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               NUM_CORES = DEF_NUM_CORES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SATURATE  = 0
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [2:0]                 op,
  input  logic [NUM_CORES-1:0]       laneEn,
  input  logic                       broadcast,
  input  logic [NUM_CORES*WIDTH-1:0] dataIn,
  output logic [NUM_CORES*WIDTH-1:0] dataOut,
  output logic [NUM_CORES-1:0]       zero,
  output logic [NUM_CORES-1:0]       ovf
);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    logic [WIDTH-1:0] load_val;

    assign load_val = broadcast ? dataIn[0 +: WIDTH]
                                : dataIn[i*WIDTH +: WIDTH];

    inc_register_lane #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk     (clk),
      .rstN    (rstN),
      .en      (laneEn[i]),
      .op      (op),
      .load_val(load_val),
      .add_val (dataIn[i*WIDTH +: WIDTH]),
      .value   (dataOut[i*WIDTH +: WIDTH]),
      .zero    (zero[i]),
      .ovf     (ovf[i])
    );
  end

endmodule

// File: tb/tb_multi_inc_register.sv
// Bench for multi_inc_register: three configs share one stimulus stream
// (plain, RESET_VAL=0x100, saturating) and are checked against a model.
module tb_multi_inc_register;

  localparam int W  = 12;
  localparam int NC = 3;

  logic          clk = 1'b0;
  logic          rstN;
  logic [2:0]    op;
  logic [NC-1:0] laneEn;
  logic          broadcast;
  logic [35:0]   dataIn;
  logic [35:0]   dout [3];
  logic [2:0]    zr   [3];
  logic [2:0]    ov   [3];

  always #5 clk = ~clk;

  multi_inc_register #(.WIDTH(W), .NUM_CORES(NC),
    .RESET_VAL(12'h000), .SATURATE(0)) dut (
    .clk(clk), .rstN(rstN), .op(op), .laneEn(laneEn),
    .broadcast(broadcast), .dataIn(dataIn),
    .dataOut(dout[0]), .zero(zr[0]), .ovf(ov[0]));

  multi_inc_register #(.WIDTH(W), .NUM_CORES(NC),
    .RESET_VAL(12'h100), .SATURATE(0)) dut_rv (
    .clk(clk), .rstN(rstN), .op(op), .laneEn(laneEn),
    .broadcast(broadcast), .dataIn(dataIn),
    .dataOut(dout[1]), .zero(zr[1]), .ovf(ov[1]));

  multi_inc_register #(.WIDTH(W), .NUM_CORES(NC),
    .RESET_VAL(12'h000), .SATURATE(1)) dut_sat (
    .clk(clk), .rstN(rstN), .op(op), .laneEn(laneEn),
    .broadcast(broadcast), .dataIn(dataIn),
    .dataOut(dout[2]), .zero(zr[2]), .ovf(ov[2]));

  int errs = 0;
  int nchk = 0;

  int mv [3][3];
  bit mo [3][3];
  int rvv  [3] = '{0, 256, 0};
  int satv [3] = '{0, 0, 1};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: integer arithmetic on each lane of each config
  task automatic model_step(bit r, int o, bit [2:0] en, bit bc, bit [35:0] d);
    int s, src, addv;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) begin
        src  = bc ? int'(d[11:0]) : int'(d[i*12 +: 12]);
        addv = int'(d[i*12 +: 12]);
        mo[c][i] = 1'b0;
        if (!r) mv[c][i] = rvv[c];
        else if (en[i]) begin
          case (o)
            1: mv[c][i] = src;
            2: begin
              s = mv[c][i] + 1;
              if (s > 4095) begin
                mo[c][i] = 1'b1;
                mv[c][i] = satv[c] ? 4095 : s - 4096;
              end else mv[c][i] = s;
            end
            3: begin
              if (mv[c][i] == 0) begin
                mo[c][i] = 1'b1;
                mv[c][i] = satv[c] ? 0 : 4095;
              end else mv[c][i] = mv[c][i] - 1;
            end
            4: begin
              s = mv[c][i] + addv;
              if (s > 4095) begin
                mo[c][i] = 1'b1;
                mv[c][i] = satv[c] ? 4095 : s - 4096;
              end else mv[c][i] = s;
            end
            5: mv[c][i] = 0;
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic model_chk();
    logic [35:0] eo;
    logic [2:0]  ez, eov;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) begin
        eo[i*12 +: 12] = 12'(mv[c][i]);
        ez[i]  = (mv[c][i] == 0);
        eov[i] = mo[c][i];
      end
      chk($sformatf("model_out[%0d]", c), 64'(dout[c]), 64'(eo));
      chk($sformatf("model_zero[%0d]", c), 64'(zr[c]), 64'(ez));
      chk($sformatf("model_ovf[%0d]", c), 64'(ov[c]), 64'(eov));
    end
  endtask

  task automatic step(bit r, logic [2:0] o, logic [2:0] en,
                      bit bc, logic [35:0] d);
    @(negedge clk);
    rstN = r; op = o; laneEn = en; broadcast = bc; dataIn = d;
    @(posedge clk);
    #1;
    model_step(r, int'(o), en, bc, d);
    model_chk();
  endtask

  typedef struct {
    logic        rstn;
    logic [2:0]  op;
    logic [2:0]  en;
    logic        bc;
    logic [35:0] din;
    logic [35:0] exp_out;
    logic [2:0]  exp_zero;
    logic [2:0]  exp_ovf;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(logic r, logic [2:0] o, logic [2:0] e,
      logic b, logic [35:0] d, logic [35:0] x, logic [2:0] z,
      logic [2:0] v);
    vec_t t;
    t.rstn = r; t.op = o; t.en = e; t.bc = b; t.din = d;
    t.exp_out = x; t.exp_zero = z; t.exp_ovf = v;
    return t;
  endfunction

  logic [35:0] snap_out [3];

  initial begin
    rstN = 1'b0; op = 3'd0; laneEn = '0; broadcast = 1'b0; dataIn = '0;

    tbl[0] = mk(0, 3'd1, 3'b111, 0, {12'd9, 12'd9, 12'd9},
                {12'h000, 12'h000, 12'h000}, 3'b111, 3'b000);
    tbl[1] = mk(1, 3'd1, 3'b101, 0, {12'd43, 12'd20, 12'd7},
                {12'd43, 12'd0, 12'd7}, 3'b010, 3'b000);
    tbl[2] = mk(1, 3'd1, 3'b111, 1, {12'd99, 12'd98, 12'd7},
                {12'd7, 12'd7, 12'd7}, 3'b000, 3'b000);
    tbl[3] = mk(1, 3'd1, 3'b001, 0, {12'd0, 12'd0, 12'hFFF},
                {12'd7, 12'd7, 12'hFFF}, 3'b000, 3'b000);
    tbl[4] = mk(1, 3'd2, 3'b001, 0, 36'd0,
                {12'd7, 12'd7, 12'h000}, 3'b001, 3'b001);
    tbl[5] = mk(1, 3'd3, 3'b001, 0, 36'd0,
                {12'd7, 12'd7, 12'hFFF}, 3'b000, 3'b001);
    tbl[6] = mk(1, 3'd7, 3'b111, 1, 36'd0,
                {12'd7, 12'd7, 12'hFFF}, 3'b000, 3'b000);
    tbl[7] = mk(1, 3'd2, 3'b000, 0, 36'd0,
                {12'd7, 12'd7, 12'hFFF}, 3'b000, 3'b000);
    tbl[8] = mk(1, 3'd4, 3'b111, 1, {12'd2, 12'hFF9, 12'd1},
                {12'd9, 12'h000, 12'h000}, 3'b011, 3'b011);
    tbl[9] = mk(1, 3'd5, 3'b010, 0, 36'd0,
                {12'd9, 12'h000, 12'h000}, 3'b011, 3'b000);

    for (int k = 0; k < 10; k++) begin
      step(tbl[k].rstn, tbl[k].op, tbl[k].en, tbl[k].bc, tbl[k].din);
      chk($sformatf("tbl%0d_out", k), 64'(dout[0]), 64'(tbl[k].exp_out));
      chk($sformatf("tbl%0d_zero", k), 64'(zr[0]), 64'(tbl[k].exp_zero));
      chk($sformatf("tbl%0d_ovf", k), 64'(ov[0]), 64'(tbl[k].exp_ovf));
      if (k == 0) begin
        chk("rv_reset_out", 64'(dout[1]), 64'h100100100);
        chk("rv_reset_zero", 64'(zr[1]), 64'd0);
        chk("rv_reset_ovf", 64'(ov[1]), 64'd0);
      end
    end

    // Saturating lane 0: INC x3 from 0xFFE, then ADD 0x010 on 0xFF8
    step(1, 3'd1, 3'b001, 0, {24'd0, 12'hFFE});
    for (int k = 0; k < 3; k++) begin
      step(1, 3'd2, 3'b001, 0, 36'd0);
      chk($sformatf("sat_inc%0d_val", k), 64'(dout[2][11:0]), 64'hFFF);
      chk($sformatf("sat_inc%0d_ovf", k), 64'(ov[2][0]), (k == 0) ? 64'd0 : 64'd1);
    end
    step(1, 3'd1, 3'b001, 0, {24'd0, 12'hFF8});
    step(1, 3'd4, 3'b001, 0, {24'd0, 12'h010});
    chk("sat_add_val", 64'(dout[2][11:0]), 64'hFFF);
    chk("sat_add_ovf", 64'(ov[2][0]), 64'd1);
    chk("wrap_add_val", 64'(dout[0][11:0]), 64'h008);
    chk("wrap_add_ovf", 64'(ov[0][0]), 64'd1);

    // Hold: illegal op or no enables for 5 cycles
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 3; i++) snap_out[c][i*12 +: 12] = 12'(mv[c][i]);
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) step(1, 3'd7, 3'b111, 1, 36'hABCDEF123);
      else            step(1, 3'd2, 3'b000, 0, 36'h111111111);
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("hold%0d_out[%0d]", k, c), 64'(dout[c]), 64'(snap_out[c]));
        chk($sformatf("hold%0d_ovf[%0d]", k, c), 64'(ov[c]), 64'd0);
      end
    end

    // Random traffic, reset occasionally asserted
    for (int k = 0; k < 200; k++) begin
      logic [35:0] d;
      logic [2:0]  o;
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0)
        d[11:0] = 12'hFF0 | 12'($urandom_range(0, 15));
      o = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 15) != 0), o, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), d);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
